// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the single-port RAM.
// The arbiter connects through the slave modport; requesters and RAM use master.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 16
);
   logic [1:0]        p0_mem_cmd;
   logic [ADDR_W-1:0] p0_mem_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic              p0_gnt;
   logic              p0_rvalid;
   logic [DATA_W-1:0] p0_rdata;

   logic [1:0]        p1_mem_cmd;
   logic [ADDR_W-1:0] p1_mem_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_gnt;
   logic              p1_rvalid;
   logic [DATA_W-1:0] p1_rdata;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_write;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;
   logic [1:0]        owner;

   modport master (
      output p0_mem_cmd, p0_mem_addr, p0_wdata,
      output p1_mem_cmd, p1_mem_addr, p1_wdata,
      output ram_dout,
      input  p0_gnt, p0_rvalid, p0_rdata,
      input  p1_gnt, p1_rvalid, p1_rdata,
      input  ram_addr, ram_write, ram_din, owner
   );

   modport slave (
      input  p0_mem_cmd, p0_mem_addr, p0_wdata,
      input  p1_mem_cmd, p1_mem_addr, p1_wdata,
      input  ram_dout,
      output p0_gnt, p0_rvalid, p0_rdata,
      output p1_gnt, p1_rvalid, p1_rdata,
      output ram_addr, ram_write, ram_din, owner
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port program/data RAM: bounded-burst round-robin,
// or strict port-0 priority when MEM_ARB_CPU_PRIO_EN is defined.
module mem_arbiter #(
   parameter int unsigned ADDR_W    = 9,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MAX_BURST = 4
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
   localparam logic [1:0] CMD_RD = 2'b10;
   localparam logic [1:0] CMD_WR = 2'b01;

   // Encodings double as the owner output value.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } st_e;

   st_e               st_q, st_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              last_owner_q, last_owner_d;   // 1 = port 1
   logic              p0_rvalid_q, p1_rvalid_q;

   logic              req0, req1, win0, win1;
   logic              gnt0_c, gnt1_c;
   logic [ADDR_W-1:0] addr_c;
   logic [DATA_W-1:0] din_c;
   logic              wr_c;

   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q         <= ST_IDLE;
         cnt_q        <= '0;
         last_owner_q <= 1'b1;
         p0_rvalid_q  <= 1'b0;
         p1_rvalid_q  <= 1'b0;
      end else begin
         st_q         <= st_d;
         cnt_q        <= cnt_d;
         last_owner_q <= last_owner_d;
         p0_rvalid_q  <= gnt0_c && (bus.p0_mem_cmd == CMD_RD);
         p1_rvalid_q  <= gnt1_c && (bus.p1_mem_cmd == CMD_RD);
      end
   end

   always_comb begin
      req0         = (bus.p0_mem_cmd == CMD_RD) || (bus.p0_mem_cmd == CMD_WR);
      req1         = (bus.p1_mem_cmd == CMD_RD) || (bus.p1_mem_cmd == CMD_WR);
      win0         = 1'b0;
      win1         = 1'b0;
      st_d         = ST_IDLE;
      cnt_d        = '0;
      last_owner_d = last_owner_q;
      cnt_inc      = (cnt_q == BURST_MAX) ? BURST_MAX : cnt_q + CNT_W'(1);
      addr_c       = '0;
      din_c        = '0;
      wr_c         = 1'b0;

      // Contention resolution; a lone requester always wins.
      if (req0 && req1) begin
`ifdef MEM_ARB_CPU_PRIO_EN
         win0 = 1'b1;
`else
         unique case (st_q)
            ST_OWN0: if (cnt_q < BURST_MAX) win0 = 1'b1; else win1 = 1'b1;
            ST_OWN1: if (cnt_q < BURST_MAX) win1 = 1'b1; else win0 = 1'b1;
            default: if (last_owner_q)      win0 = 1'b1; else win1 = 1'b1;
         endcase
`endif
      end else begin
         win0 = req0;
         win1 = req1;
      end

      if (win0) begin
         st_d         = ST_OWN0;
         last_owner_d = 1'b0;
         cnt_d        = (st_q == ST_OWN0) ? cnt_inc : CNT_W'(1);
         addr_c       = bus.p0_mem_addr;
         din_c        = bus.p0_wdata;
         wr_c         = (bus.p0_mem_cmd == CMD_WR);
      end else if (win1) begin
         st_d         = ST_OWN1;
         last_owner_d = 1'b1;
         cnt_d        = (st_q == ST_OWN1) ? cnt_inc : CNT_W'(1);
         addr_c       = bus.p1_mem_addr;
         din_c        = bus.p1_wdata;
         wr_c         = (bus.p1_mem_cmd == CMD_WR);
      end
`ifdef MEM_ARB_CPU_PRIO_EN
      cnt_d = '0;
`endif

      // Reset masks every side effect that reaches the RAM or a requester.
      gnt0_c = win0 && reset;
      gnt1_c = win1 && reset;
      wr_c   = wr_c && reset;
   end

   assign bus.p0_gnt    = gnt0_c;
   assign bus.p1_gnt    = gnt1_c;
   assign bus.ram_addr  = addr_c;
   assign bus.ram_din   = din_c;
   assign bus.ram_write = wr_c;
   assign bus.p0_rvalid = p0_rvalid_q;
   assign bus.p1_rvalid = p1_rvalid_q;
   assign bus.p0_rdata  = bus.ram_dout;
   assign bus.p1_rdata  = bus.ram_dout;
   assign bus.owner     = st_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, read-data scoreboard and per-scenario grant checks.
module tb_mem_arbiter;
   localparam int unsigned AW = 9;
   localparam int unsigned DW = 16;
   localparam int unsigned MB = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] ram    [512];
   logic [DW-1:0] shadow [512];
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];

   // Single-port RAM with registered read data
   always @(posedge clk) begin
      if (bus.ram_write) ram[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= ram[bus.ram_addr];
   end

   // Expected read data is taken from the bench's own shadow copy at grant time.
   always @(negedge clk) begin
      #1;
      if (bus.p0_gnt && bus.p0_mem_cmd == 2'b10) q0.push_back(shadow[bus.p0_mem_addr]);
      if (bus.p0_gnt && bus.p0_mem_cmd == 2'b01) shadow[bus.p0_mem_addr] = bus.p0_wdata;
      if (bus.p1_gnt && bus.p1_mem_cmd == 2'b10) q1.push_back(shadow[bus.p1_mem_addr]);
      if (bus.p1_gnt && bus.p1_mem_cmd == 2'b01) shadow[bus.p1_mem_addr] = bus.p1_wdata;
   end

   // Read return must arrive exactly one cycle after its grant.
   always @(posedge clk) begin
      logic [DW-1:0] e;
      #1;
      total++;
      if (q0.size() != 0) begin
         e = q0.pop_front();
         if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== e) begin
            bad++;
            $display("FAIL sb_p0 rvalid=%b rdata=%h expected rvalid=1 rdata=%h", bus.p0_rvalid, bus.p0_rdata, e);
         end
      end else if (bus.p0_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL sb_p0_spurious rvalid=%b expected 0", bus.p0_rvalid);
      end
      total++;
      if (q1.size() != 0) begin
         e = q1.pop_front();
         if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== e) begin
            bad++;
            $display("FAIL sb_p1 rvalid=%b rdata=%h expected rvalid=1 rdata=%h", bus.p1_rvalid, bus.p1_rdata, e);
         end
      end else if (bus.p1_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL sb_p1_spurious rvalid=%b expected 0", bus.p1_rvalid);
      end
   end

   task automatic drive(input logic [1:0] c0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [1:0] c1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      @(negedge clk);
      bus.p0_mem_cmd = c0; bus.p0_mem_addr = a0; bus.p0_wdata = d0;
      bus.p1_mem_cmd = c1; bus.p1_mem_addr = a1; bus.p1_wdata = d1;
   endtask

   task automatic idle();
      drive(2'b00, '0, '0, 2'b00, '0, '0);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(2'b10, 9'h001, '0, 2'b10, 9'h002, '0);
         #2;
         total++;
         if ({bus.p0_gnt, bus.p1_gnt, bus.ram_write} !== 3'b000) begin
            bad++;
            $display("FAIL reset_gnt gnt0/gnt1/wr=%b expected 000", {bus.p0_gnt, bus.p1_gnt, bus.ram_write});
         end
         @(posedge clk); #1;
         total++;
         if (bus.owner !== 2'b00) begin
            bad++;
            $display("FAIL reset_owner owner=%b expected 00", bus.owner);
         end
      end
      idle();
      reset = 1'b1;
   endtask

   task automatic test_single_read();
      drive(2'b10, 9'h005, '0, 2'b00, '0, '0);
      #2;
      total++;
      if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0 || bus.ram_addr !== 9'h005 || bus.ram_write !== 1'b0) begin
         bad++;
         $display("FAIL read_p0_gnt gnt0=%b gnt1=%b addr=%h wr=%b expected 1 0 005 0",
                  bus.p0_gnt, bus.p1_gnt, bus.ram_addr, bus.ram_write);
      end
      @(posedge clk); #1;
      total++;
      if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 16'hABCD || bus.p1_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL read_p0_data rvalid0=%b rdata=%h rvalid1=%b expected 1 abcd 0",
                  bus.p0_rvalid, bus.p0_rdata, bus.p1_rvalid);
      end
      idle();
   endtask

   task automatic test_single_write();
      drive(2'b00, '0, '0, 2'b01, 9'h010, 16'h1234);
      #2;
      total++;
      if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0 || bus.ram_write !== 1'b1 ||
          bus.ram_din !== 16'h1234 || bus.ram_addr !== 9'h010) begin
         bad++;
         $display("FAIL write_p1 gnt1=%b gnt0=%b wr=%b din=%h addr=%h expected 1 0 1 1234 010",
                  bus.p1_gnt, bus.p0_gnt, bus.ram_write, bus.ram_din, bus.ram_addr);
      end
      @(posedge clk); #1;
      total++;
      if (bus.owner !== 2'b10 || bus.p1_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL write_p1_owner owner=%b rvalid1=%b expected 10 0", bus.owner, bus.p1_rvalid);
      end
      // Read back through port 1; data checked by the scoreboard.
      drive(2'b00, '0, '0, 2'b10, 9'h010, '0);
      #2;
      total++;
      if (bus.p1_gnt !== 1'b1 || bus.ram_write !== 1'b0) begin
         bad++;
         $display("FAIL readback_p1 gnt1=%b wr=%b expected 1 0", bus.p1_gnt, bus.ram_write);
      end
      idle();
   endtask

   task automatic test_burst();
      logic e0;
      for (int k = 0; k < 12; k++) begin
         drive(2'b10, 9'h021, '0, 2'b10, 9'h042, '0);
         #2;
`ifdef MEM_ARB_CPU_PRIO_EN
         e0 = 1'b1;
`else
         e0 = ((k / 4) % 2) == 0;
`endif
         total++;
         if (bus.p0_gnt !== e0 || bus.p1_gnt !== !e0) begin
            bad++;
            $display("FAIL burst_cycle%0d gnt0=%b gnt1=%b expected %b %b", k, bus.p0_gnt, bus.p1_gnt, e0, !e0);
         end
      end
      drive(2'b00, '0, '0, 2'b10, 9'h042, '0);
      #2;
      total++;
      if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0) begin
         bad++;
         $display("FAIL burst_release gnt1=%b gnt0=%b expected 1 0", bus.p1_gnt, bus.p0_gnt);
      end
      idle();
   endtask

   task automatic test_saturate();
      logic e0;
      for (int k = 0; k < 6; k++) begin
         drive(2'b10, 9'(9'h060 + k), '0, 2'b00, '0, '0);
         #2;
         total++;
         if (bus.p0_gnt !== 1'b1) begin
            bad++;
            $display("FAIL solo_p0_%0d gnt0=%b expected 1", k, bus.p0_gnt);
         end
      end
`ifdef MEM_ARB_CPU_PRIO_EN
      e0 = 1'b1;
`else
      e0 = 1'b0;
`endif
      drive(2'b01, 9'h070, 16'h0F0F, 2'b01, 9'h071, 16'hF0F0);
      #2;
      total++;
      if (bus.p0_gnt !== e0 || bus.p1_gnt !== !e0 || bus.ram_write !== 1'b1) begin
         bad++;
         $display("FAIL saturate gnt0=%b gnt1=%b wr=%b expected %b %b 1", bus.p0_gnt, bus.p1_gnt, bus.ram_write, e0, !e0);
      end
      idle();
   endtask

   task automatic test_idle_rr();
      logic e0;
      drive(2'b00, '0, '0, 2'b10, 9'h080, '0);
      idle();
      drive(2'b10, 9'h081, '0, 2'b10, 9'h082, '0);
      #2;
      total++;
      if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
         bad++;
         $display("FAIL idle_rr_a gnt0=%b gnt1=%b expected 1 0", bus.p0_gnt, bus.p1_gnt);
      end
      @(posedge clk); #1;
      total++;
      if (bus.owner !== 2'b01) begin
         bad++;
         $display("FAIL idle_rr_owner owner=%b expected 01", bus.owner);
      end
      idle();
      @(posedge clk); #1;
      total++;
      if (bus.owner !== 2'b00) begin
         bad++;
         $display("FAIL idle_owner owner=%b expected 00", bus.owner);
      end
`ifdef MEM_ARB_CPU_PRIO_EN
      e0 = 1'b1;
`else
      e0 = 1'b0;
`endif
      drive(2'b10, 9'h083, '0, 2'b10, 9'h084, '0);
      #2;
      total++;
      if (bus.p0_gnt !== e0 || bus.p1_gnt !== !e0) begin
         bad++;
         $display("FAIL idle_rr_b gnt0=%b gnt1=%b expected %b %b", bus.p0_gnt, bus.p1_gnt, e0, !e0);
      end
      idle();
   endtask

   task automatic test_reset_mid();
      drive(2'b00, '0, '0, 2'b10, 9'h090, '0);
      #2;
      total++;
      if (bus.p1_gnt !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre gnt1=%b expected 1", bus.p1_gnt);
      end
      drive(2'b10, 9'h091, '0, 2'b10, 9'h092, '0);
      reset = 1'b0;
      #2;
      total++;
      if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0 || bus.ram_write !== 1'b0) begin
         bad++;
         $display("FAIL mid_gnt gnt0=%b gnt1=%b wr=%b expected 0 0 0", bus.p0_gnt, bus.p1_gnt, bus.ram_write);
      end
      @(posedge clk); #1;
      total++;
      if (bus.p1_rvalid !== 1'b0 || bus.owner !== 2'b00) begin
         bad++;
         $display("FAIL mid_drop rvalid1=%b owner=%b expected 0 00", bus.p1_rvalid, bus.owner);
      end
      @(negedge clk);
      reset = 1'b1;
      #2;
      total++;
      if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
         bad++;
         $display("FAIL mid_after gnt0=%b gnt1=%b expected 1 0", bus.p0_gnt, bus.p1_gnt);
      end
      idle();
   endtask

   initial begin
      reset = 1'b0;
      bus.p0_mem_cmd = 2'b00; bus.p0_mem_addr = '0; bus.p0_wdata = '0;
      bus.p1_mem_cmd = 2'b00; bus.p1_mem_addr = '0; bus.p1_wdata = '0;
      for (int i = 0; i < 512; i++) begin
         ram[i]    = (16'(i) * 16'h0097) ^ 16'h5A5A;
         shadow[i] = (16'(i) * 16'h0097) ^ 16'h5A5A;
      end
      ram[5]    = 16'hABCD;
      shadow[5] = 16'hABCD;

      test_reset();
      test_single_read();
      test_single_write();
      idle();
      test_burst();
      test_saturate();
      test_idle_rr();
      test_reset_mid();
      idle();
      idle();
      @(posedge clk); #2;
      total++;
      if (q0.size() != 0 || q1.size() != 0) begin
         bad++;
         $display("FAIL sb_drain q0=%0d q1=%0d expected 0 0", q0.size(), q1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
